// File: rtl/preg_free_list_pkg.sv
// Shared sizing, types and pointer helpers for the physical-register free list.
package preg_free_list_pkg;
  localparam int MACHINE_WIDTH = 2;
  localparam int ISSUE_WIDTH   = 4;
  localparam int PREG_NUM      = 128;
  localparam int INIT_MAPPED   = 70;
  localparam int ALLOC_PORTS   = MACHINE_WIDTH;
  localparam int RELEASE_PORTS = ISSUE_WIDTH;
  localparam int PREG_W        = $clog2(PREG_NUM);
  localparam int PTR_W         = PREG_W + 1;
  localparam int ACNT_W        = $clog2(ALLOC_PORTS + 1);
  localparam int RCNT_W        = $clog2(RELEASE_PORTS + 1);

  typedef logic [PREG_W-1:0]                     preg_addr_t;
  typedef logic [PTR_W-1:0]                      fl_ptr_t;
  typedef preg_addr_t [ALLOC_PORTS-1:0]          alloc_ids_t;
  typedef preg_addr_t [RELEASE_PORTS-1:0]        rel_ids_t;

  // Pointers carry a wrap bit; storage is indexed by the low bits only.
  function automatic preg_addr_t fl_idx(fl_ptr_t p);
    return p[PTR_W-2:0];
  endfunction
endpackage

// File: rtl/preg_free_list_if.sv
// Rename/commit side bundle of the free list.
interface preg_free_list_if import preg_free_list_pkg::*; ();
  logic [ALLOC_PORTS-1:0]   alloc_req;
  logic                     alloc_ok;
  alloc_ids_t               alloc_id;
  logic [ACNT_W-1:0]        commit_num;
  logic [RELEASE_PORTS-1:0] release_valid;
  rel_ids_t                 release_id;
  logic                     flush;
  fl_ptr_t                  free_count;

  modport master (output alloc_req, commit_num, release_valid, release_id, flush,
                  input  alloc_ok, alloc_id, free_count);
  modport slave  (input  alloc_req, commit_num, release_valid, release_id, flush,
                  output alloc_ok, alloc_id, free_count);
endinterface

// File: rtl/preg_free_list_fl_prefix_count.sv
// Per-lane exclusive popcount of lower lanes, plus the vector total.
module fl_prefix_count #(
  parameter int N = 4,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0]        vec,
  output logic [N-1:0][W-1:0] pre,
  output logic [W-1:0]        total
);
  logic [W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      pre[i] = acc;
      acc    = acc + W'(vec[i]);
    end
    total = acc;
  end
endmodule

// File: rtl/preg_free_list.sv
// Circular free list of preg ids: speculative head feeds rename, commit head
// marks retired allocations, tail receives released ids.
module preg_free_list import preg_free_list_pkg::*; (
  input  logic             clk,
  input  logic             resetn,
  preg_free_list_if.slave  fl
);
  logic [ALLOC_PORTS-1:0][ACNT_W-1:0]   a_pre;
  logic [ACNT_W-1:0]                    a_tot;
  logic [RELEASE_PORTS-1:0][RCNT_W-1:0] r_pre;
  logic [RCNT_W-1:0]                    r_tot;

  fl_prefix_count #(.N(ALLOC_PORTS),   .W(ACNT_W)) u_apc (.vec(fl.alloc_req),     .pre(a_pre), .total(a_tot));
  fl_prefix_count #(.N(RELEASE_PORTS), .W(RCNT_W)) u_rpc (.vec(fl.release_valid), .pre(r_pre), .total(r_tot));

  preg_addr_t fl_mem [PREG_NUM];
  fl_ptr_t    spec_head, commit_head, tail;
  fl_ptr_t    free_cnt, alloc_n, spec_head_nxt, commit_head_nxt, tail_nxt;
  logic       ok, fire;

  assign free_cnt      = tail - spec_head;
  assign ok            = free_cnt >= fl_ptr_t'(ALLOC_PORTS);
  assign fl.free_count = free_cnt;
  assign fl.alloc_ok   = ok;

  // Idle lanes look at spec_head+k so the next ids are visible with no request.
  for (genvar k = 0; k < ALLOC_PORTS; k++) begin : g_lane
    fl_ptr_t off;
    assign off            = fl.alloc_req[k] ? fl_ptr_t'(a_pre[k]) : fl_ptr_t'(k);
    assign fl.alloc_id[k] = fl_mem[fl_idx(spec_head + off)];
  end

  assign fire            = ok && !fl.flush;
  assign alloc_n         = fire ? fl_ptr_t'(a_tot) : '0;
  assign commit_head_nxt = commit_head + fl_ptr_t'(fl.commit_num);
  assign spec_head_nxt   = fl.flush ? commit_head_nxt : spec_head + alloc_n;
  assign tail_nxt        = tail + fl_ptr_t'(r_tot);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= fl_ptr_t'(PREG_NUM - INIT_MAPPED);
      for (int i = 0; i < PREG_NUM; i++)
        fl_mem[i] <= (i < PREG_NUM - INIT_MAPPED) ? preg_addr_t'(INIT_MAPPED + i) : '0;
    end else begin
      spec_head   <= spec_head_nxt;
      commit_head <= commit_head_nxt;
      tail        <= tail_nxt;
      for (int j = 0; j < RELEASE_PORTS; j++)
        if (fl.release_valid[j])
          fl_mem[fl_idx(tail + fl_ptr_t'(r_pre[j]))] <= fl.release_id[j];
    end
  end

`ifndef SYNTHESIS
  a_overfill: assert property (@(posedge clk) disable iff (!resetn)
    (fl_ptr_t'(tail_nxt - spec_head_nxt) <= fl_ptr_t'(PREG_NUM)));
  a_commit:   assert property (@(posedge clk) disable iff (!resetn)
    (fl_ptr_t'(fl.commit_num) <= fl_ptr_t'(spec_head + alloc_n - commit_head)));
  a_alloc:    assert property (@(posedge clk) disable iff (!resetn)
    fire |-> (free_cnt >= fl_ptr_t'(a_tot)));
`endif
endmodule

// File: tb/tb_preg_free_list.sv
// Random + directed bench; reference keeps the list as a queue of ids from the commit point.
module tb_preg_free_list;
  import preg_free_list_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  preg_free_list_if fl_if ();
  preg_free_list dut (.clk(clk), .resetn(resetn), .fl(fl_if.slave));

  int total = 0;
  int bad   = 0;
  int fifo[$];   // ids from commit point to tail
  int held[$];   // ids owned outside the list
  int spec_off;  // allocated but not committed

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    fl_if.alloc_req     = '0;
    fl_if.commit_num    = '0;
    fl_if.release_valid = '0;
    fl_if.release_id    = '0;
    fl_if.flush         = 1'b0;
  endtask

  task automatic model_reset();
    fifo.delete();
    held.delete();
    for (int i = 0; i < PREG_NUM - INIT_MAPPED; i++) fifo.push_back(INIT_MAPPED + i);
    for (int i = 0; i < INIT_MAPPED; i++) held.push_back(i);
    spec_off = 0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  // Entered and left at a negedge; checks combinational outputs, then advances one cycle.
  task automatic step(input logic [ALLOC_PORTS-1:0] req, input int cnum,
                      input logic [RELEASE_PORTS-1:0] rv, input rel_ids_t rid, input logic fl);
    int free, rank, n;
    fl_if.alloc_req     = req;
    fl_if.commit_num    = ACNT_W'(cnum);
    fl_if.release_valid = rv;
    fl_if.release_id    = rid;
    fl_if.flush         = fl;
    #1;
    free = fifo.size() - spec_off;
    chk("free_count", int'(fl_if.free_count), free);
    chk("alloc_ok", int'(fl_if.alloc_ok), int'(free >= ALLOC_PORTS));
    rank = 0;
    if (free >= ALLOC_PORTS)
      for (int k = 0; k < ALLOC_PORTS; k++)
        if (req[k]) begin
          chk($sformatf("alloc_id[%0d]", k), int'(fl_if.alloc_id[k]), fifo[spec_off + rank]);
          rank++;
        end
    n = (free >= ALLOC_PORTS && !fl) ? $countones(req) : 0;
    spec_off += n;
    for (int c = 0; c < cnum; c++) held.push_back(fifo.pop_front());
    spec_off -= cnum;
    if (fl) spec_off = 0;
    for (int j = 0; j < RELEASE_PORTS; j++)
      if (rv[j]) begin
        for (int h = 0; h < held.size(); h++)
          if (held[h] == int'(rid[j])) begin
            held.delete(h);
            break;
          end
        fifo.push_back(int'(rid[j]));
      end
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  initial begin
    rel_ids_t rid;
    logic [RELEASE_PORTS-1:0] rv;
    int cnum, pick;

    idle();
    @(negedge clk);
    resetn = 1'b1;
    model_reset();

    // reset state, no traffic
    #1;
    chk("rst free_count", int'(fl_if.free_count), 58);
    chk("rst alloc_ok", int'(fl_if.alloc_ok), 1);
    chk("rst id0", int'(fl_if.alloc_id[0]), 70);
    chk("rst id1", int'(fl_if.alloc_id[1]), 71);
    @(negedge clk);

    // full drain, then a request while empty must be ignored
    for (int i = 0; i < 29; i++) step(2'b11, 0, '0, '0, 1'b0);
    #1;
    chk("drain free_count", int'(fl_if.free_count), 0);
    chk("drain alloc_ok", int'(fl_if.alloc_ok), 0);
    @(negedge clk);
    step(2'b11, 0, '0, '0, 1'b0);
    #1;
    chk("empty req free_count", int'(fl_if.free_count), 0);
    @(negedge clk);

    // single lane request on lane 1
    do_reset();
    step(2'b10, 0, '0, '0, 1'b0);
    #1;
    chk("lane1 next id0", int'(fl_if.alloc_id[0]), 71);
    @(negedge clk);

    // release into an empty list, compacted
    do_reset();
    for (int i = 0; i < 29; i++) step(2'b11, 0, '0, '0, 1'b0);
    rid = '0;
    rid[0] = 7'd5;
    rid[2] = 7'd9;
    step(2'b00, 0, 4'b0101, rid, 1'b0);
    #1;
    chk("rel free_count", int'(fl_if.free_count), 2);
    chk("rel id0", int'(fl_if.alloc_id[0]), 5);
    chk("rel id1", int'(fl_if.alloc_id[1]), 9);
    @(negedge clk);

    // commit two of six then flush
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b11, 0, '0, '0, 1'b0);
    step(2'b00, 1, '0, '0, 1'b0);
    step(2'b00, 1, '0, '0, 1'b1);
    #1;
    chk("flush free_count", int'(fl_if.free_count), 56);
    chk("flush id0", int'(fl_if.alloc_id[0]), 72);
    @(negedge clk);
    step(2'b01, 0, '0, '0, 1'b0);

    // async reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 24; i++) step(2'b11, 0, '0, '0, 1'b0);
    #1;
    chk("burst free_count", int'(fl_if.free_count), 10);
    #2;
    resetn = 1'b0;
    #1;
    chk("async free_count", int'(fl_if.free_count), 58);
    chk("async alloc_ok", int'(fl_if.alloc_ok), 1);
    chk("async id0", int'(fl_if.alloc_id[0]), 70);
    chk("async id1", int'(fl_if.alloc_id[1]), 71);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      cnum = $urandom_range(0, (spec_off < ALLOC_PORTS) ? spec_off : ALLOC_PORTS);
      rv   = RELEASE_PORTS'($urandom);
      rid  = '0;
      for (int j = 0; j < RELEASE_PORTS; j++)
        if (rv[j]) begin
          if (held.size() == 0) rv[j] = 1'b0;
          else begin
            pick   = $urandom_range(0, held.size() - 1);
            rid[j] = preg_addr_t'(held[pick]);
            held.delete(pick);
          end
        end
      step(ALLOC_PORTS'($urandom), cnum, rv, rid, ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
